// File: rtl/ddr_rd_forward_arbiter.sv
// Round-robin owner arbiter for the shared DDR read path, with a post-release idle gap.
// Define DDR_FWD_TIMEOUT_EN to add the ownership hold timeout and the o_timeout pulse.
module ddr_rd_forward_arbiter #(
  parameter int P_REQ_NUM         = 4,
  parameter int P_ID_WIDTH        = 2,
  parameter int P_GAP_CYCLES      = 2,
  parameter int P_HOLD_MAX_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [P_REQ_NUM-1:0]  i_forward_req,
  output logic [P_REQ_NUM-1:0]  o_forward_resp,
  input  logic [P_REQ_NUM-1:0]  i_forward_finish,
  output logic                  o_grant_valid,
  output logic [P_ID_WIDTH-1:0] o_grant_id,
  output logic                  o_busy
`ifdef DDR_FWD_TIMEOUT_EN
  ,
  output logic                  o_timeout
`endif
);

  // state | meaning
  // IDLE  | no owner; arbitrate pending requests round-robin from rr_ptr
  // OWNED | one requester owns the read path until it finishes (or times out)
  // GAP   | idle gap after release so the read engine can drain

  if (P_REQ_NUM < 2 || P_REQ_NUM > 16 || P_ID_WIDTH < $clog2(P_REQ_NUM) ||
      P_GAP_CYCLES < 0 || P_GAP_CYCLES > 255 || P_HOLD_MAX_CYCLES < 1) begin : g_param_err
    $error("ddr_rd_forward_arbiter: illegal parameter combination");
  end

  localparam int                   GAP_W     = 8;
  localparam logic [P_REQ_NUM-1:0] ONE_HOT_0 = P_REQ_NUM'(1);
  localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(P_GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [P_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [P_REQ_NUM-1:0]  resp_q, resp_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [P_ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;

`ifdef DDR_FWD_TIMEOUT_EN
  localparam int                HOLD_W    = $clog2(P_HOLD_MAX_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(P_HOLD_MAX_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  logic [P_REQ_NUM-1:0]  mask_hi;
  logic [P_REQ_NUM-1:0]  req_hi;
  logic [P_REQ_NUM-1:0]  pick_src;
  logic [P_ID_WIDTH-1:0] win_id;
  logic [P_ID_WIDTH-1:0] rr_next;
  logic                  req_any;
  logic                  owner_fin;
  logic                  release_now;

  // Requests at or above rr_ptr take precedence; otherwise wrap to the lowest index.
  always_comb begin
    mask_hi  = ~((ONE_HOT_0 << rr_ptr_q) - ONE_HOT_0);
    req_hi   = i_forward_req & mask_hi;
    pick_src = (|req_hi) ? req_hi : i_forward_req;
    win_id   = '0;
    for (int i = P_REQ_NUM - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        win_id = P_ID_WIDTH'(i);
      end
    end
    rr_next = (win_id == P_ID_WIDTH'(P_REQ_NUM - 1)) ? '0 : win_id + P_ID_WIDTH'(1);
  end

  assign req_any   = |i_forward_req;
  assign owner_fin = |(i_forward_finish & (ONE_HOT_0 << grant_id_q));

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gap_cnt_d     = gap_cnt_q;
    resp_d        = '0;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    release_now   = 1'b0;
`ifdef DDR_FWD_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d       = ST_OWNED;
          resp_d        = ONE_HOT_0 << win_id;
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          busy_d        = 1'b1;
          rr_ptr_d      = rr_next;
`ifdef DDR_FWD_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end
      end

      ST_OWNED: begin
        release_now = owner_fin;
`ifdef DDR_FWD_TIMEOUT_EN
        // A finish landing on the expiry cycle wins and is a normal release.
        if (!owner_fin) begin
          if (hold_cnt_q >= HOLD_LAST) begin
            release_now = 1'b1;
            timeout_d   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
`endif
        if (release_now) begin
          grant_valid_d = 1'b0;
          if (P_GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
          busy_d    = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      gap_cnt_q     <= '0;
      resp_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gap_cnt_q     <= gap_cnt_d;
      resp_q        <= resp_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
    end
  end

`ifdef DDR_FWD_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`endif

  assign o_forward_resp = resp_q;
  assign o_grant_valid  = grant_valid_q;
  assign o_grant_id     = grant_id_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_ddr_rd_forward_arbiter.sv
// Scoreboard bench for ddr_rd_forward_arbiter: predicted grant ids are queued when
// requests are driven and checked against each resp pulse.
module tb_ddr_rd_forward_arbiter;

  localparam int N        = 4;
  localparam int GAP      = 2;
  localparam int HOLD_MAX = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] fin;
  logic [3:0] resp;
  logic       valid;
  logic [1:0] gid;
  logic       busy;
`ifdef DDR_FWD_TIMEOUT_EN
  logic       tmo;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int m_ptr   = 0;

  ddr_rd_forward_arbiter #(
    .P_REQ_NUM        (N),
    .P_ID_WIDTH       (2),
    .P_GAP_CYCLES     (GAP),
    .P_HOLD_MAX_CYCLES(HOLD_MAX)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_forward_req   (req),
    .o_forward_resp  (resp),
    .i_forward_finish(fin),
    .o_grant_valid   (valid),
    .o_grant_id      (gid),
    .o_busy          (busy)
`ifdef DDR_FWD_TIMEOUT_EN
    ,
    .o_timeout       (tmo)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [3:0] m, input int ptr);
    logic [1:0] idx;
    for (int k = 0; k < N; k++) begin
      idx = 2'((ptr + k) % N);
      if (m[idx]) return int'(idx);
    end
    return -1;
  endfunction

  function automatic logic [3:0] bit_of(input int w);
    return 4'(1) << w;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst && resp != 4'b0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_resp", 32'(resp), 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sb_resp", 32'(resp), 32'(bit_of(e)));
        check("sb_id", 32'(gid), e);
        check("sb_valid", 32'(valid), 1);
      end
    end
  end

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (resp == 4'b0 && n < 40);
    check("resp_seen", 32'(resp != 4'b0), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    fin = '0;
    repeat (2) tick();
    check("rst_resp", 32'(resp), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_id", 32'(gid), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef DDR_FWD_TIMEOUT_EN
    check("rst_timeout", 32'(tmo), 0);
`endif
    rst   = 1'b0;
    m_ptr = 0;
    tick();
  endtask

  task automatic do_grant(input logic [3:0] mask, input int hold, input bit drop,
                          input bit foreign, output int id, output int lat);
    int w;
    int n;
    req = mask;
    w   = model_pick(mask, m_ptr);
    exp_q.push_back(w);
    m_ptr = (w + 1) % N;
    wait_resp(lat);
    id = int'(gid);
    check("own_valid", 32'(valid), 1);
    check("own_busy", 32'(busy), 1);
    if (drop) req = req & ~bit_of(w);
    if (foreign) begin
      fin = ~bit_of(w);
      tick();
      fin = '0;
      check("foreign_fin_valid", 32'(valid), 1);
      check("foreign_fin_id", 32'(gid), w);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(valid), 1);
      check("hold_id", 32'(gid), w);
    end
    fin = bit_of(w);
    tick();
    fin = '0;
    check("rel_valid", 32'(valid), 0);
    check("rel_resp", 32'(resp), 0);
`ifdef DDR_FWD_TIMEOUT_EN
    check("rel_timeout", 32'(tmo), 0);
`endif
    n = 0;
    while (busy && n < 300) begin
      n++;
      tick();
    end
    check("gap_len", n, GAP);
  endtask

  initial begin
    int id;
    int lat;
    int n;
    int seq[5] = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    req = '0;
    fin = '0;
    do_reset();

    // single requester, finish 5 cycles after resp
    do_grant(4'b0001, 5, 1'b1, 1'b0, id, lat);
    check("t1_lat", lat, 1);
    check("t1_id", id, 0);

    // all requesting continuously
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_grant(4'b1111, 3, 1'b0, 1'b0, id, lat);
      check("rr_seq", id, seq[k]);
    end

    // rr_ptr steering: grant 1, then {0,3} picks 3, then 0
    do_grant(4'b0010, 2, 1'b1, 1'b0, id, lat);
    check("t3_first", id, 1);
    do_grant(4'b1001, 2, 1'b1, 1'b0, id, lat);
    check("t3_ptr2", id, 3);
    do_grant(4'b0001, 2, 1'b1, 1'b0, id, lat);
    check("t3_wrap", id, 0);

    // finish pulses from non-owners must not release owner 2
    do_grant(4'b0100, 4, 1'b1, 1'b1, id, lat);
    check("t4_id", id, 2);

    // finish in the same cycle as resp
    do_grant(4'b0010, 0, 1'b1, 1'b0, id, lat);
    check("t5_id", id, 1);

    // reset in the middle of an ownership
    req = 4'b0001;
    exp_q.push_back(model_pick(4'b0001, m_ptr));
    m_ptr = (model_pick(4'b0001, m_ptr) + 1) % N;
    wait_resp(lat);
    check("t6_id", 32'(gid), 0);
    req = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_resp", 32'(resp), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_id", 32'(gid), 0);
    check("mid_rst_busy", 32'(busy), 0);
`ifdef DDR_FWD_TIMEOUT_EN
    check("mid_rst_timeout", 32'(tmo), 0);
`endif
    rst   = 1'b0;
    m_ptr = 0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    do_grant(4'b1000, 1, 1'b1, 1'b0, id, lat);
    check("post_rst_id", id, 3);
    check("post_rst_lat", lat, 1);

`ifdef DDR_FWD_TIMEOUT_EN
    // owner 0 never finishes; requester 1 waits
    req = 4'b0001;
    exp_q.push_back(model_pick(4'b0001, m_ptr));
    m_ptr = (model_pick(4'b0001, m_ptr) + 1) % N;
    wait_resp(lat);
    req = 4'b0010;
    exp_q.push_back(model_pick(4'b0010, m_ptr));
    m_ptr = (model_pick(4'b0010, m_ptr) + 1) % N;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tmo && n < 40);
    check("to_lat", n, HOLD_MAX);
    check("to_valid", 32'(valid), 0);
    check("to_busy", 32'(busy), 1);
    fin = 4'b0001;
    tick();
    fin = '0;
    check("to_pulse_width", 32'(tmo), 0);
    check("late_fin_busy", 32'(busy), 1);
    n = 1;
    while (resp == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    check("to_next_lat", n, GAP + 1);
    check("to_next_id", 32'(gid), 1);
    req = '0;
    repeat (15) tick();
    check("expiry_hold_valid", 32'(valid), 1);
    fin = 4'b0010;
    tick();
    fin = '0;
    check("expiry_fin_timeout", 32'(tmo), 0);
    check("expiry_fin_valid", 32'(valid), 0);
    repeat (GAP) tick();
    check("expiry_gap_done", 32'(busy), 0);
`endif

    repeat (3) tick();
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/ddr_rd_forward_arbiter.md
Name: ddr_rd_forward_arbiter

Overview:
- Grants exclusive use of the shared DDR read path to one of P_REQ_NUM forward requesters at a time, using round-robin order.
- Requesters are the uplink/downlink port forwarders. Each uses a forward_req / forward_resp / forward_finish handshake.
- Sits between the per-port DDR read controllers and the DDR read engine. Only the granted port may issue DDR read bursts.
- Inserts a configurable idle gap between ownerships so the DDR read engine can drain.

Parameters:
- P_REQ_NUM, 4, number of requesters (2..16).
- P_ID_WIDTH, 2, width of grant id; must be at least clog2(P_REQ_NUM).
- P_GAP_CYCLES, 2, idle cycles after release before the next grant (0..255).
- P_HOLD_MAX_CYCLES, 4096, ownership timeout; used only with DDR_FWD_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_forward_req  in  P_REQ_NUM  level request, one bit per requester.
- o_forward_resp  out  P_REQ_NUM  one-cycle grant pulse; at most one bit high.
- i_forward_finish  in  P_REQ_NUM  one-cycle release pulse from the owner.
- o_grant_valid  out  1  high while a requester owns the DDR read path.
- o_grant_id  out  P_ID_WIDTH  index of the current owner; valid only when o_grant_valid=1.
- o_busy  out  1  high in OWNED and GAP states.
- o_timeout  out  1  one-cycle forced-release pulse; present only with DDR_FWD_TIMEOUT_EN.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer rr_ptr goes to 0.
  - Gap and hold counters go to 0.
  - Reset mid-ownership drops the grant immediately. No finish is needed afterwards.
- States: IDLE, OWNED, GAP. All outputs are registered.
- IDLE:
  - If any i_forward_req bit is high, pick the winner as the first set bit scanning upward from rr_ptr, wrapping modulo P_REQ_NUM.
  - Next cycle: o_forward_resp[winner]=1 for exactly one cycle, o_grant_id=winner, o_grant_valid=1, o_busy=1.
  - rr_ptr updates to (winner+1) mod P_REQ_NUM. State goes to OWNED.
  - Latency from req seen to resp is 1 cycle.
- OWNED:
  - Holds until i_forward_finish[o_grant_id]=1. Finish is accepted even in the same cycle that resp is high.
  - Finish bits from non-owners are ignored.
  - New requests are not evaluated while OWNED.
  - On finish: o_grant_valid goes to 0 next cycle.
  - If P_GAP_CYCLES=0, go to IDLE; otherwise load the gap counter with P_GAP_CYCLES and go to GAP.
- GAP:
  - Counter decrements each cycle. At 1, go to IDLE.
  - o_busy=1 and o_grant_valid=0 throughout.
  - With P_GAP_CYCLES=0, the next grant's resp can appear 2 cycles after finish: finish edge, then IDLE arbitration, then resp.
- Requester obligations:
  - Hold req until its resp is seen, then drop req within 1 cycle.
  - A req bit still high in IDLE is treated as a new request.
  - Once resp is issued, the owner must pulse finish even if it no longer needs the path.
- Simultaneous requests resolve by rr_ptr order. Example: rr_ptr=2 with reqs {0,3} grants 3; a later re-request from 0 is served next.
- Single requester: the same requester can be re-granted after every gap with no starvation of others. After each grant its priority drops to lowest.

Optional Feature:
- Macro: DDR_FWD_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every grant and increments each OWNED cycle.
  - If it reaches P_HOLD_MAX_CYCLES without finish, the arbiter force-releases: o_timeout pulses for 1 cycle, o_grant_valid drops, and the state enters GAP exactly as for a normal finish.
  - A finish arriving in the same cycle as expiry counts as a normal release with no o_timeout.
  - A late finish from the timed-out owner is ignored.
- Not defined: the o_timeout port and hold counter are absent, and ownership is unbounded.

Test Plan:
- Reset then req=0001: resp=0001 one cycle later, grant_id=0, grant_valid=1. Finish[0] 5 cycles later: grant_valid=0 next cycle, busy=1 for 2 GAP cycles, then busy=0.
- req=1111 held continuously with every owner finishing after 3 cycles: grants occur in order 0,1,2,3,0. Each resp is exactly one cycle wide and never overlaps another.
- rr_ptr=2 (after granting 1) with req=1001: grant_id=3. Then with req=0001: grant_id=0.
- While requester 2 owns: finish[1] and finish[3] pulse → no release. Then finish[2] → release.
- Finish[owner] asserted in the same cycle as resp: grant held for exactly 1 cycle, then GAP.
- DDR_FWD_TIMEOUT_EN with P_HOLD_MAX_CYCLES=16 and owner never finishing: o_timeout pulses once 16 cycles into OWNED, grant_valid=0, and the next pending request is granted after GAP. Reset asserted mid-OWNED: all outputs are 0 next cycle.
